multicycle_control_fsm: RTL
===========================

// Module: multicycle_control_fsm
// PURPOSE
//  Multicycle control unit of the RV32 subset datapath. Sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK.
//  Drives the 4-bit `estado` bus consumed by the instruction decoder, which captures fields in state 4'b0001.
//  Generates the per-state datapath enables and the PC update, and runs the memory ready handshake.
//  Flags illegal opcodes and counts retired instructions.
// PARAMETERS
//  CNT_W   32   width of retired-instruction counter (wraps modulo 2^CNT_W)
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      synchronous reset, active-low
//  run          in   1      1 = allow a new fetch; sampled only in FETCH
//  opcode       in   7      instruction[6:0] from the instruction register (stable from DECODE on)
//  funct3       in   3      instruction[14:12] from the instruction register
//  alu_zero     in   1      ALU result == 0
//  alu_neg      in   1      ALU result sign (signed a<b on SUB)
//  mem_ready    in   1      memory completed the current access this cycle
//  estado       out  4      current state code (registered)
//  mem_req      out  1      memory access request (fetch or data)
//  mem_we       out  1      1 = write access (store)
//  ir_write     out  1      load the instruction register from memory data
//  pc_write     out  1      PC <= next PC this cycle
//  pc_src       out  1      0 = PC+4, 1 = PC+branch offset
//  alu_src_imm  out  1      ALU operand B = immediate
//  alu_sub      out  1      ALU performs SUB (branch compare)
//  reg_write    out  1      register file write enable
//  mem_to_reg   out  1      writeback data: 0 = ALU, 1 = memory
//  illegal      out  1      sticky; set on an unknown opcode group
//  retired      out  CNT_W  count of completed instructions
// BEHAVIOUR
//  State codes:
//    FETCH=0000, DECODE=0001, EXEC_R=0010, EXEC_I=0011, ADDR=0100, MEM_RD=0101,
//    MEM_WR=0110, WB_ALU=0111, WB_MEM=1000, BRANCH=1001, TRAP=1111.
//  Reset (rst_n=0 at a clk edge), overriding all else:
//    estado=FETCH, illegal=0, retired=0; in-flight access abandoned, no write issued.
//  Outputs are a Moore decode of estado; every output not listed for a state is 0.
//  FETCH
//    - With run=1: mem_req=1.
//    - mem_ready=1: ir_write=1, pc_write=1, pc_src=0, go to DECODE.
//    - Otherwise hold in FETCH.
//    - run=0: no request, hold.
//  DECODE (1 cycle, no enables): dispatch on opcode[6:4].
//    - 000 (load) -> ADDR
//    - 001 (I-ALU) -> EXEC_I
//    - 010 (store) -> ADDR
//    - 011 (R) -> EXEC_R
//    - 110 (branch) -> BRANCH
//    - any other -> TRAP
//  EXEC_R: go to WB_ALU.
//  EXEC_I: alu_src_imm=1, go to WB_ALU.
//  ADDR: alu_src_imm=1. Load goes to MEM_RD; store goes to MEM_WR.
//  MEM_RD: mem_req=1. Hold until mem_ready, then go to WB_MEM.
//  MEM_WR: mem_req=1, mem_we=1. Hold until mem_ready, then retire and go to FETCH.
//  WB_ALU: reg_write=1, retire, go to FETCH.
//  WB_MEM: reg_write=1, mem_to_reg=1, retire, go to FETCH.
//  BRANCH: alu_sub=1.
//    - taken = funct3[2] ? (alu_neg ^ funct3[0]) : (alu_zero ^ funct3[0]).
//    - pc_write=taken, pc_src=1; retire, go to FETCH.
//    - funct3 010/011 is treated as not taken.
//  TRAP: illegal=1, all enables 0, stay until reset. retired does not increment.
//  Retire: retired += 1 on the edge leaving the retiring state; wraps from all-ones to 0.
//  PC offset note: pc_src=1 uses PC+offset. PC was already incremented in FETCH, so the datapath subtracts 4.
//  Latency with mem_ready=1 throughout: R / I-ALU / store = 4 cycles, load = 5, branch = 3.
//  mem_ready is ignored outside FETCH, MEM_RD and MEM_WR.
// TESTING
//  1. Hold rst_n=0 for 2 cycles while run=1 and mem_ready=1.
//     -> estado=0000, retired=0, illegal=0, mem_req=1 only after rst_n=1.
//  2. Send R-type (opcode 0110011) with mem_ready=1.
//     -> estado 0000,0001,0010,0111,0000; reg_write high only in 0111; retired=1.
//  3. Send a load with mem_ready low for 3 cycles in MEM_RD.
//     -> estado holds 0101 for 4 cycles with mem_req=1; then 1000 with mem_to_reg=1.
//  4. Send a store.
//     -> MEM_WR asserts mem_we=1 and mem_req=1; reg_write never asserted; 4 cycles total.
//  5. Send BEQ (funct3=000) with alu_zero=1, then with alu_zero=0; then BLT (funct3=100) with alu_neg=1.
//     -> pc_write=1, 0, 1 respectively in state 1001.
//  6. Send opcode 1010011.
//     -> estado=1111, illegal=1, retired unchanged; rst_n=0 then clears to FETCH.
//  Also preload retired to all-ones, then retire one instruction.
//     -> retired wraps to 0.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Multicycle control unit for the RV32 subset datapath.
// Sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK, runs the memory handshake and counts retired instructions.
module multicycle_control_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             alu_zero,
  input  logic             alu_neg,
  input  logic             mem_ready,
  output logic [3:0]       estado,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             alu_src_imm,
  output logic             alu_sub,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    FETCH  = 4'b0000,
    DECODE = 4'b0001,
    EXEC_R = 4'b0010,
    EXEC_I = 4'b0011,
    ADDR   = 4'b0100,
    MEM_RD = 4'b0101,
    MEM_WR = 4'b0110,
    WB_ALU = 4'b0111,
    WB_MEM = 4'b1000,
    BRANCH = 4'b1001,
    TRAP   = 4'b1111
  } state_t;

  state_t state;
  logic   retire;
  logic   taken;
  logic   unused_opcode_low;

  assign estado            = state;
  assign unused_opcode_low = ^opcode[3:0];

  // funct3 010/011 have no compare meaning here and fall through as not taken.
  assign taken = funct3[2] ? (alu_neg ^ funct3[0])
                           : (!funct3[1] && (alu_zero ^ funct3[0]));

  assign retire = (state == WB_ALU) || (state == WB_MEM) || (state == BRANCH) ||
                  ((state == MEM_WR) && mem_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= FETCH;
      illegal <= 1'b0;
      retired <= '0;
    end else begin
      case (state)
        FETCH:  if (run && mem_ready) state <= DECODE;
        DECODE: begin
          case (opcode[6:4])
            3'b000, 3'b010: state <= ADDR;
            3'b001:         state <= EXEC_I;
            3'b011:         state <= EXEC_R;
            3'b110:         state <= BRANCH;
            default: begin
              state   <= TRAP;
              illegal <= 1'b1;
            end
          endcase
        end
        EXEC_R, EXEC_I:         state <= WB_ALU;
        ADDR:                   state <= (opcode[6:4] == 3'b010) ? MEM_WR : MEM_RD;
        MEM_RD: if (mem_ready)  state <= WB_MEM;
        MEM_WR: if (mem_ready)  state <= FETCH;
        WB_ALU, WB_MEM, BRANCH: state <= FETCH;
        TRAP:                   state <= TRAP;
        default:                state <= TRAP;
      endcase
      if (retire) retired <= retired + 1'b1;
    end
  end

  // Enables decode the registered state; gating with rst_n keeps a reset
  // cycle from issuing a request or a write while the state is being cleared.
  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 1'b0;
    alu_src_imm = 1'b0;
    alu_sub     = 1'b0;
    reg_write   = 1'b0;
    mem_to_reg  = 1'b0;
    if (rst_n) begin
      case (state)
        FETCH: begin
          mem_req  = run;
          ir_write = run && mem_ready;
          pc_write = run && mem_ready;
        end
        EXEC_I, ADDR: alu_src_imm = 1'b1;
        MEM_RD: mem_req = 1'b1;
        MEM_WR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
        end
        WB_ALU: reg_write = 1'b1;
        WB_MEM: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        BRANCH: begin
          alu_sub  = 1'b1;
          pc_src   = 1'b1;
          pc_write = taken;
        end
        default: ;
      endcase
    end
  end

endmodule
